// File: rtl/fpga_clock_pkg.sv
// Shared types for the sync-pulse gate: FSM state encoding and debounce counter sizing.
package fpga_clock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_RUNNING,
    ST_STOPPING,
    ST_DONE
  } gate_state_e;

  // The debounce counter holds 0 .. cycles-1, so it never needs more than clog2(cycles) bits.
  function automatic int db_cnt_w(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/gpio_debounce.sv
// 2-FF synchroniser plus stability counter for a raw GPIO line.
// The output follows the synchronised input once it has held for DEBOUNCE_CYCLES clocks.
module gpio_debounce
  import fpga_clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam int CNT_W = db_cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_q, en_s_q, en_db_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      en_s_q <= 1'b0;
    end else begin
      meta_q <= din;
      en_s_q <= meta_q;
    end
  end

  // Counting only while en_s disagrees with the accepted level means any bounce back
  // to the old level clears the count, which is the same as clearing on every en_s change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      en_db_q <= 1'b0;
    end else if (en_s_q != en_db_q) begin
      if (cnt_q == CNT_LAST) begin
        cnt_q   <= '0;
        en_db_q <= en_s_q;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_q <= '0;
    end
  end

  assign dout = en_db_q;

endmodule

// File: rtl/sync_gate_ctrl.sv
// Gate in front of the Toggle stage: arms on enable, starts on a divider pulse, and only
// stops after an even number of flips. Optional pulse-limit auto-stop via SYNC_GATE_LIMIT_EN.
module sync_gate_ctrl
  import fpga_clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int COUNT_W         = 32,
  parameter int PULSE_LIMIT     = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable_raw,
  input  logic               pulse,
  output logic               toggle_enable,
  output logic               running,
  output logic [COUNT_W-1:0] pulse_count,
  output logic               done
);

  if (DEBOUNCE_CYCLES < 1 || PULSE_LIMIT < 2 || (PULSE_LIMIT % 2) != 0) begin : g_bad_param
    $error("sync_gate_ctrl: DEBOUNCE_CYCLES must be >=1 and PULSE_LIMIT even and >=2");
  end

  logic en_db;

  gpio_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_en_db (
    .clk   (clk),
    .reset (reset),
    .din   (enable_raw),
    .dout  (en_db)
  );

  gate_state_e        state_q, state_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d, cnt_inc, cnt_n;
  logic               running_q, running_d, done_q, done_d;
  logic               sat;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sat     = &cnt_q;
    cnt_inc = sat ? cnt_q : cnt_q + COUNT_W'(1);
    cnt_n   = pulse ? cnt_inc : cnt_q;

    unique case (state_q)
      // Level check: a rise seen during STOPPING still arms here if enable is still high.
      ST_IDLE: begin
        if (en_db) begin
          state_d = ST_ARMED;
          cnt_d   = '0;
        end
      end
      ST_ARMED: begin
        if (!en_db)     state_d = ST_IDLE;
        else if (pulse) state_d = ST_RUNNING;
      end
      ST_RUNNING: begin
        cnt_d = cnt_n;
`ifdef SYNC_GATE_LIMIT_EN
        if (pulse && cnt_n == COUNT_W'(PULSE_LIMIT)) state_d = ST_DONE;
        else if (!en_db)                              state_d = ST_STOPPING;
`else
        if (!en_db) state_d = ST_STOPPING;
`endif
      end
      // A saturated count is stuck odd, so the next pulse is taken as the closing flip.
      ST_STOPPING: begin
        cnt_d = cnt_n;
        if (!cnt_n[0] || (pulse && sat)) state_d = ST_IDLE;
      end
`ifdef SYNC_GATE_LIMIT_EN
      ST_DONE: begin
        if (!en_db) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    running_d = (state_d == ST_RUNNING) || (state_d == ST_STOPPING);
`ifdef SYNC_GATE_LIMIT_EN
    done_d = (state_d == ST_DONE);
`else
    done_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign toggle_enable = (state_q == ST_RUNNING) || (state_q == ST_STOPPING);
  assign running       = running_q;
  assign pulse_count   = cnt_q;
  assign done          = done_q;

endmodule

// File: tb/tb_sync_gate_ctrl.sv
// Directed bench for sync_gate_ctrl: DEBOUNCE_CYCLES=4, pulse every 10 clks, second
// instance with a 2-bit counter to exercise saturation.
module tb_sync_gate_ctrl;

  localparam int PERIOD = 10;
`ifdef SYNC_GATE_LIMIT_EN
  localparam logic LIM = 1'b1;
`else
  localparam logic LIM = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, enable_raw, pulse;
  logic       toggle_enable, running, done;
  logic [7:0] pulse_count;
  logic       sat_toggle, sat_running, sat_done;
  logic [1:0] sat_count;

  int n_chk  = 0;
  int n_pass = 0;
  int ph     = 0;

  always #5 clk = ~clk;

  sync_gate_ctrl #(.DEBOUNCE_CYCLES(4), .COUNT_W(8), .PULSE_LIMIT(6)) u_dut (
    .clk           (clk),
    .reset         (reset),
    .enable_raw    (enable_raw),
    .pulse         (pulse),
    .toggle_enable (toggle_enable),
    .running       (running),
    .pulse_count   (pulse_count),
    .done          (done)
  );

  sync_gate_ctrl #(.DEBOUNCE_CYCLES(4), .COUNT_W(2), .PULSE_LIMIT(2)) u_sat (
    .clk           (clk),
    .reset         (reset),
    .enable_raw    (enable_raw),
    .pulse         (pulse),
    .toggle_enable (sat_toggle),
    .running       (sat_running),
    .pulse_count   (sat_count),
    .done          (sat_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  // One clock: pulse is driven for the upcoming edge, outputs are stable #1 after it.
  task automatic cyc();
    pulse = (ph == PERIOD - 1);
    @(posedge clk);
    ph = (ph == PERIOD - 1) ? 0 : ph + 1;
    #1;
  endtask

  task automatic cycn(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic run_to_pulse();
    for (int i = 0; i < PERIOD; i++) begin
      logic hit;
      hit = (ph == PERIOD - 1);
      cyc();
      if (hit) return;
    end
  endtask

  task automatic chk_out(input string tag, input logic te, input logic rn, input int cnt);
    chk({tag, ".toggle_enable"}, 32'(toggle_enable), 32'(te));
    chk({tag, ".running"},       32'(running),       32'(rn));
    chk({tag, ".pulse_count"},   32'(pulse_count),   32'(cnt));
  endtask

  initial begin
    reset      = 1'b1;
    enable_raw = 1'b0;
    pulse      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 1'b0, 1'b0, 0);
    chk("reset.done", 32'(done), 32'd0);
    reset = 1'b0;

    // 1: a 3-clk glitch never reaches en_db
    enable_raw = 1'b1;
    cycn(3);
    enable_raw = 1'b0;
    cycn(12);
    chk_out("glitch", 1'b0, 1'b0, 0);

    // 2: en_db rises at edge 6, ARMED at 7, pulse at edge 8 starts the run
    ph = 2;
    enable_raw = 1'b1;
    cycn(7);
    chk_out("armed", 1'b0, 1'b0, 0);
    cyc();
    chk_out("start", 1'b1, 1'b1, 0);
    run_to_pulse();
    chk_out("first_flip", 1'b1, 1'b1, 1);

    // 3: stop requested at odd count, closes on the 4th flip
    run_to_pulse();
    run_to_pulse();
    enable_raw = 1'b0;
    cycn(8);
    chk_out("stop_odd_wait", 1'b1, 1'b1, 3);
    cyc();
    chk("stop_odd_hold", 32'(toggle_enable), 32'd1);
    cyc();
    chk_out("stop_odd_exit", 1'b0, 1'b0, 4);

    // 4: stop at even count with no pulse pending exits one clk after STOPPING
    enable_raw = 1'b1;
    cycn(10);
    chk_out("rearm", 1'b1, 1'b1, 0);
    repeat (4) run_to_pulse();
    chk_out("four_flips", 1'b1, 1'b1, 4);
    enable_raw = 1'b0;
    cycn(7);
    chk_out("stop_even_enter", 1'b1, 1'b1, 4);
    cyc();
    chk_out("stop_even_exit", 1'b0, 1'b0, 4);
`ifndef SYNC_GATE_LIMIT_EN
    chk("sat.count", 32'(sat_count), 32'd3);
    chk("sat.hold", 32'(sat_toggle), 32'd1);
    chk("sat.running", 32'(sat_running), 32'd1);
    chk("sat.done", 32'(sat_done), 32'd0);
`endif
    cycn(2);
    chk_out("no_fifth_flip", 1'b0, 1'b0, 4);
`ifndef SYNC_GATE_LIMIT_EN
    chk("sat.exit", 32'(sat_toggle), 32'd0);
`endif

    // 5: reset mid-run clears everything at once, then re-arms after 6 clks
    enable_raw = 1'b1;
    cycn(10);
    repeat (7) run_to_pulse();
    chk_out("count7", 1'b1, 1'b1, 7);
    reset = 1'b1;
    #1;
    chk_out("async_reset", 1'b0, 1'b0, 0);
    chk("async_reset.done", 32'(done), 32'd0);
    cycn(2);
    reset = 1'b0;
    ph = 2;
    cycn(7);
    chk_out("reset_armed", 1'b0, 1'b0, 0);
    cyc();
    chk_out("reset_rearm", 1'b1, 1'b1, 0);

    // 6: with the limit built in, the 6th flip ends the run in DONE
    repeat (5) run_to_pulse();
    chk_out("count5", 1'b1, 1'b1, 5);
    chk("count5.done", 32'(done), 32'd0);
    run_to_pulse();
    chk_out("limit", !LIM, !LIM, 6);
    chk("limit.done", 32'(done), 32'(LIM));
    enable_raw = 1'b0;
    cycn(8);
    chk_out("final_idle", 1'b0, 1'b0, 6);
    chk("final_idle.done", 32'(done), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
